// File: rtl/exp_ctrl_defs.sv
// Shared state codes and mux select constants
// for the exponential series sequencer.
package exp_ctrl_defs;

  localparam int ST_W = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t INIT  = 3'd1;
  localparam state_t MUL   = 3'd2;
  localparam state_t MWAIT = 3'd3;
  localparam state_t ADD   = 3'd4;
  localparam state_t DONE  = 3'd5;

  localparam logic SEL_ONE  = 1'b0;
  localparam logic SEL_PROD = 1'b1;

endpackage

// File: rtl/term_counter.sv
// Series term counter: clear/increment, flags
// the final term so increment never wraps.
module term_counter #(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_V =
    CNT_W'(N_TERMS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

  assign last = (cnt == LAST_V);

endmodule

// File: rtl/exp_seq_controller.sv
// Sequencer for the Taylor-series exp datapath:
// drives load/select strobes and the multiplier handshake.
module exp_seq_controller
  import exp_ctrl_defs::*;
#(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mulDone,
  output logic             ldX,
  output logic             ldTmp,
  output logic             selTmp,
  output logic             initSum,
  output logic             ldSum,
  output logic             mulStart,
  output logic [CNT_W-1:0] coefAddr,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt;

  term_counter #(
    .N_TERMS (N_TERMS),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    ldX      = 1'b0;
    ldTmp    = 1'b0;
    selTmp   = SEL_ONE;
    initSum  = 1'b0;
    ldSum    = 1'b0;
    mulStart = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          nxt = INIT;
      end
      INIT: begin
        ldX     = 1'b1;
        ldTmp   = 1'b1;
        selTmp  = SEL_ONE;
        initSum = 1'b1;
        busy    = 1'b1;
        cnt_clr = 1'b1;
        nxt     = MUL;
      end
      MUL: begin
        mulStart = 1'b1;
        busy     = 1'b1;
        nxt      = MWAIT;
      end
      MWAIT: begin
        busy = 1'b1;
        // product is captured in the same cycle the pulse arrives
        if (mulDone) begin
          ldTmp  = 1'b1;
          selTmp = SEL_PROD;
          nxt    = ADD;
        end
      end
      ADD: begin
        ldSum = 1'b1;
        busy  = 1'b1;
        if (cnt_last) begin
          nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
          nxt     = MUL;
        end
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign coefAddr = cnt;

endmodule

// File: tb/tb_exp_seq_controller.sv
// Bench for exp_seq_controller: three instances
// (N_TERMS 4,1,8) against a cycle-schedule model.
module tb_exp_seq_controller;

  localparam int NI = 3;
  localparam int NTS [NI] = '{4, 1, 8};

  localparam int B_LDX  = 7;
  localparam int B_LDT  = 6;
  localparam int B_SEL  = 5;
  localparam int B_INI  = 4;
  localparam int B_LDS  = 3;
  localparam int B_MST  = 2;
  localparam int B_BUSY = 1;
  localparam int B_DONE = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic md [NI];
  wire [7:0] ov [NI];
  wire [2:0] ca [NI];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int c0 = 0;

  bit spur [NI];
  bit pend [NI][64];
  bit act [NI];
  int c0r [NI];
  int lr [NI];

  int n_done [NI];
  int n_ms [NI];
  int n_ls [NI];
  int n_ldx [NI];
  int n_is [NI];
  int first_done [NI];
  int second_ldx [NI];
  int max_ca [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    logic ldX, ldTmp, selTmp, initSum;
    logic ldSum, mulStart, busy, done;
    logic [2:0] coefAddr;

    exp_seq_controller #(
      .N_TERMS (NTS[g]),
      .CNT_W   (3)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mulDone  (md[g]),
      .ldX      (ldX),
      .ldTmp    (ldTmp),
      .selTmp   (selTmp),
      .initSum  (initSum),
      .ldSum    (ldSum),
      .mulStart (mulStart),
      .coefAddr (coefAddr),
      .busy     (busy),
      .done     (done)
    );

    assign ov[g] = {ldX, ldTmp, selTmp, initSum,
                    ldSum, mulStart, busy, done};
    assign ca[g] = coefAddr;
  end

  // Expected outputs d cycles after the start-sampling cycle.
  // A run is INIT, then n periods of (MUL, l waits, ADD), then DONE.
  function automatic logic [7:0] model_out(
    input int n, input int d, input int l, output int k);
    int prd, fin, r;
    logic [7:0] e;
    e = '0;
    k = -1;
    prd = l + 2;
    fin = 2 + n * prd;
    if (d == 1) begin
      e[B_LDX] = 1'b1;
      e[B_LDT] = 1'b1;
      e[B_INI] = 1'b1;
      e[B_BUSY] = 1'b1;
    end else if (d >= 2 && d < fin) begin
      k = (d - 2) / prd;
      r = (d - 2) % prd;
      e[B_BUSY] = 1'b1;
      if (r == 0) begin
        e[B_MST] = 1'b1;
      end else if (r == l) begin
        e[B_LDT] = 1'b1;
        e[B_SEL] = 1'b1;
      end else if (r == l + 1) begin
        e[B_LDS] = 1'b1;
      end
    end else if (d == fin) begin
      e[B_DONE] = 1'b1;
      e[B_BUSY] = 1'b1;
    end
    return e;
  endfunction

  // multiplier responder: cycle counter and mulDone drive
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      for (int i = 0; i < NI; i++) begin
        md[i] = pend[i][cyc % 64] | spur[i];
        pend[i][cyc % 64] = 1'b0;
      end
    end
  end

  // per-cycle compare against the schedule model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int d, k;
      logic [7:0] e;
      if (rst) begin
        e = '0;
        k = 0;
        act[i] = 1'b0;
        for (int j = 0; j < 64; j++)
          pend[i][j] = 1'b0;
      end else begin
        d = act[i] ? cyc - c0r[i] : 0;
        e = model_out(NTS[i], d, lr[i], k);
      end
      total++;
      if (ov[i] !== e || (k >= 0 && ca[i] !== 3'(k))) begin
        bad++;
        $display("FAIL cycle_check cyc=%0d inst=%0d actual=%b addr=%0d required=%b addr=%0d",
                 cyc, i, ov[i], ca[i], e, k);
      end
      if (!rst) begin
        if (!e[B_BUSY] && start) begin
          act[i] = 1'b1;
          c0r[i] = cyc;
          lr[i] = lat;
        end
        if (ov[i][B_MST]) begin
          pend[i][(cyc + lat) % 64] = 1'b1;
          n_ms[i]++;
          if (int'(ca[i]) > max_ca[i])
            max_ca[i] = int'(ca[i]);
        end
        if (ov[i][B_DONE]) begin
          n_done[i]++;
          if (n_done[i] == 1)
            first_done[i] = cyc;
        end
        if (ov[i][B_LDX]) begin
          n_ldx[i]++;
          if (n_ldx[i] == 2)
            second_ldx[i] = cyc;
        end
        if (ov[i][B_LDS])
          n_ls[i]++;
        if (ov[i][B_INI])
          n_is[i]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int a, input int r);
    total++;
    if (a != r) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, r);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NI; i++) begin
      n_done[i] = 0;
      n_ms[i] = 0;
      n_ls[i] = 0;
      n_ldx[i] = 0;
      n_is[i] = 0;
      first_done[i] = -1;
      second_ldx[i] = -1;
      max_ca[i] = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      md[i] = 1'b0;
      spur[i] = 1'b0;
    end
    clear_stats();
    rst = 1'b1;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk("reset_outs", int'(ov[i]), 0);
      chk("reset_addr", int'(ca[i]), 0);
    end
    rst = 1'b0;
    repeat (2) step();

    // single start, L=1
    clear_stats();
    lat = 1;
    pulse_start();
    repeat (35) step();
    chk("n4_l1_done_cyc", first_done[0] - c0, 14);
    chk("n4_l1_ndone", n_done[0], 1);
    chk("n4_l1_nmulstart", n_ms[0], 4);
    chk("n4_l1_nldsum", n_ls[0], 4);
    chk("n1_l1_done_cyc", first_done[1] - c0, 5);
    chk("n8_l1_done_cyc", first_done[2] - c0, 26);
    chk("n8_nldsum", n_ls[2], 8);
    chk("n8_nldx", n_ldx[2], 1);
    chk("n8_ninitsum", n_is[2], 1);
    chk("n8_max_addr", max_ca[2], 7);

    // single start, L=3
    clear_stats();
    lat = 3;
    pulse_start();
    repeat (50) step();
    chk("n4_l3_done_cyc", first_done[0] - c0, 22);
    chk("n8_l3_done_cyc", first_done[2] - c0, 42);

    // spurious mulDone in IDLE/MUL/ADD, start during MWAIT
    clear_stats();
    lat = 1;
    spur[0] = 1'b1;
    step();
    spur[0] = 1'b0;
    step();
    start = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
    step();
    spur[0] = 1'b1;
    step();
    spur[0] = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    spur[0] = 1'b1;
    step();
    spur[0] = 1'b0;
    repeat (35) step();
    chk("spur_done_cyc", first_done[0] - c0, 14);
    chk("spur_ndone", n_done[0], 1);
    chk("spur_nmulstart", n_ms[0], 4);
    chk("spur_nldsum", n_ls[0], 4);

    // start held high, back-to-back runs
    clear_stats();
    lat = 1;
    start = 1'b1;
    c0 = cyc;
    repeat (20) step();
    start = 1'b0;
    repeat (45) step();
    chk("held_n1_done_cyc", first_done[1] - c0, 5);
    chk("held_n1_reinit_cyc", second_ldx[1] - c0, 7);
    chk("held_n1_ndone", n_done[1], 4);
    chk("held_n1_nldx", n_ldx[1], 4);

    // reset in the middle of MWAIT
    clear_stats();
    lat = 3;
    pulse_start();
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("midrst_outs", int'(ov[0]), 0);
    chk("midrst_addr", int'(ca[0]), 0);
    step();
    rst = 1'b0;
    clear_stats();
    repeat (30) step();
    for (int i = 0; i < NI; i++)
      chk("midrst_no_done", n_done[i], 0);
    clear_stats();
    pulse_start();
    repeat (50) step();
    chk("post_rst_done_cyc", first_done[0] - c0, 22);
    chk("post_rst_ndone", n_done[0], 1);
    chk("post_rst_nmulstart", n_ms[0], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
